pmu_snapshot_collector: RTL and testbench
=========================================

# pmu_snapshot_collector

Sequencer downstream of the loader-driven mesh with per-node PMUs. After a traffic run it waits for every loader to report idle, then walks the PMU counter address space, reads each counter over the `pmu_addr`/`pmu_data` ports, and streams the snapshot out as one valid/ready packet. The cosimulation harness uses it to dump all PMU statistics without per-node software polling.

## Interface
- `NUM_PMU`, 16: number of monitored PMUs (1..256).
- `NUM_CNT`, 32: counters per PMU; addresses 0..NUM_CNT-1 (1..32).
- `CNT_WIDTH`, 64: counter/data width (≥24).
- `READ_LAT`, 1: cycles from `pmu_addr_o` change to valid `pmu_data_i` (0..3).
- `SETTLE_CYCLES`, 8: cycles all-idle must hold before the scan starts (1..255).

- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `start_i` in 1: single-cycle snapshot request.
- `idle_i` in [NUM_PMU]×1: loader idle flags.
- `pmu_addr_o` out [NUM_PMU]×5: counter address, same value broadcast to all PMUs.
- `pmu_data_i` in [NUM_PMU]×CNT_WIDTH: PMU read data.
- `out_tvalid_o` out 1: stream word valid.
- `out_tready_i` in 1: stream sink ready.
- `out_tdata_o` out CNT_WIDTH: stream word.
- `out_tlast_o` out 1: last word of the snapshot.
- `busy_o` out 1: high from accepted start until DONE.
- `done_o` out 1: one-cycle pulse after the last handshake.

## Operation
- States: IDLE, WAIT_IDLE, ADDR, WAIT_DATA, OUT, DONE.
- IDLE: `start_i`=1 → WAIT_IDLE, clear settle counter, pmu index p=0, counter index c=0.
- WAIT_IDLE: AND of all `idle_i` high increments settle counter; any low clears it. Reaching SETTLE_CYCLES → ADDR.
- ADDR: drive all `pmu_addr_o`=c for one cycle → WAIT_DATA with latency counter = READ_LAT.
- WAIT_DATA: decrement to 0, then capture `pmu_data_i[p]` into the output register → OUT.
- OUT: `out_tvalid_o`=1. On handshake: if c<NUM_CNT-1, c++ → ADDR; else if p<NUM_PMU-1, p++, c=0 → ADDR; else → DONE.
- DONE: `done_o`=1 for one cycle → IDLE.
- Word order: PMU 0 counters 0..NUM_CNT-1, then PMU 1, and so on. Total NUM_PMU×NUM_CNT words; 512 at defaults.
- `out_tlast_o`=1 only on the final word (p=NUM_PMU-1, c=NUM_CNT-1).
- `start_i` is ignored when not in IDLE.
- `idle_i` is not monitored after WAIT_IDLE.
- `pmu_addr_o` holds its last value outside ADDR/WAIT_DATA.

## Timing
- Reset values: state IDLE; all `pmu_addr_o`=0; `out_tvalid_o`, `out_tlast_o`, `busy_o`, `done_o`=0; `out_tdata_o`=0; p, c and all counters 0.
- `busy_o` rises the cycle after `start_i` is sampled and falls in the DONE cycle. `done_o` and `busy_o` are never high together.
- All outputs are registered.
- Address → tvalid latency: READ_LAT+2 cycles (ADDR, READ_LAT WAIT_DATA cycles, capture edge).
- With `out_tready_i` held high, one word takes READ_LAT+3 cycles.
- Data and last stay stable while tvalid=1 and tready=0; tvalid never drops without a handshake.
- Scan starts at least SETTLE_CYCLES+1 cycles after `start_i`.
- Reset asserted mid-scan: immediate return to reset values; no partial tlast. The sink must discard the incomplete packet.

## Configuration
- `PMU_COLLECT_HEADER_EN` defined: each PMU block is preceded by one header word.
  - Header fields: [63:56]=8'hA5, [55:48]=p, [47:40]=NUM_CNT, rest 0.
  - Header is emitted from a HDR state entered before ADDR for c=0 and takes one cycle plus handshake.
  - Total words: NUM_PMU×(NUM_CNT+1); tlast still marks the final counter word.
- Undefined: no HDR state; stream is counters only.

## Test plan
- Defaults; PMU i counter a returns {i,a} pattern; tready=1; start with all idle → 512 words in order, tlast only on word 511, done pulse once, `busy_o` high for SETTLE+1+512×4 cycles ±1.
- `idle_i[5]` low for 20 cycles after start, toggling once mid-settle → first ADDR exactly 8 cycles after the last idle rise.
- Random tready backpressure (30% ready) → no word lost or duplicated; tdata/tlast stable while stalled.
- READ_LAT=3 with PMU model delaying data by 3 cycles → every captured value correct; READ_LAT=0 with combinational model → correct.
- Reset pulsed during word 100 → all outputs 0 next cycle; new start yields a full 512-word packet from PMU 0 counter 0.
- `PMU_COLLECT_HEADER_EN` defined → 528 words; word 33 = 64'hA501_2000_0000_0000; extra start pulses while busy are ignored.

Source files
------------

// File: rtl/pmu_snapshot_collector.sv
// pmu_snapshot_collector
// Waits for all loaders to settle idle, then walks every PMU counter address,
// reads each counter and streams the whole snapshot as one valid/ready packet.
// Optional build macro: PMU_COLLECT_HEADER_EN -- prefixes each PMU block with
// a header word {8'hA5, pmu index, NUM_CNT} in the top bits of the word.
module pmu_snapshot_collector #(
    parameter int NUM_PMU       = 16,
    parameter int NUM_CNT       = 32,
    parameter int CNT_WIDTH     = 64,
    parameter int READ_LAT      = 1,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               start_i,
    input  logic [NUM_PMU-1:0]                 idle_i,
    output logic [NUM_PMU-1:0][4:0]            pmu_addr_o,
    input  logic [NUM_PMU-1:0][CNT_WIDTH-1:0]  pmu_data_i,
    output logic                               out_tvalid_o,
    input  logic                               out_tready_i,
    output logic [CNT_WIDTH-1:0]               out_tdata_o,
    output logic                               out_tlast_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int              PW          = (NUM_PMU > 1) ? $clog2(NUM_PMU) : 1;
    localparam logic [PW-1:0]   P_LAST      = PW'(NUM_PMU - 1);
    localparam logic [4:0]      C_LAST      = 5'(NUM_CNT - 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0]      LAT_INIT    = 2'(READ_LAT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        ADDR,
        WAIT_DATA,
        OUT,
`ifdef PMU_COLLECT_HEADER_EN
        HDR,
`endif
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   p, p_nxt;
    logic [4:0]      c, c_nxt;
    logic [7:0]      settle, settle_nxt;
    logic [1:0]      lat, lat_nxt;
    logic            capture;
    logic            hs;

    assign hs = out_tvalid_o && out_tready_i;

`ifdef PMU_COLLECT_HEADER_EN
    logic [CNT_WIDTH-1:0] hdr_word;
    // Header fields sit in the top 24 bits of the stream word
    assign hdr_word = CNT_WIDTH'({8'hA5, 8'(p_nxt), 8'(NUM_CNT)}) << (CNT_WIDTH - 24);
`endif

    // State and scan index registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            p      <= '0;
            c      <= '0;
            settle <= '0;
            lat    <= '0;
        end else begin
            state  <= state_nxt;
            p      <= p_nxt;
            c      <= c_nxt;
            settle <= settle_nxt;
            lat    <= lat_nxt;
        end
    end

    // Next-state, scan index and capture decisions
    always_comb begin
        state_nxt  = state;
        p_nxt      = p;
        c_nxt      = c;
        settle_nxt = settle;
        lat_nxt    = lat;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt  = WAIT_IDLE;
                    settle_nxt = '0;
                    p_nxt      = '0;
                    c_nxt      = '0;
                end
            end
            WAIT_IDLE: begin
                if (&idle_i) begin
                    if (settle == SETTLE_LAST) begin
                        settle_nxt = '0;
`ifdef PMU_COLLECT_HEADER_EN
                        state_nxt  = HDR;
`else
                        state_nxt  = ADDR;
`endif
                    end else begin
                        settle_nxt = settle + 8'd1;
                    end
                end else begin
                    settle_nxt = '0;
                end
            end
            ADDR: begin
                state_nxt = WAIT_DATA;
                lat_nxt   = LAT_INIT;
            end
            WAIT_DATA: begin
                if (lat == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end else begin
                    lat_nxt = lat - 2'd1;
                end
            end
            OUT: begin
                if (hs) begin
                    if (c != C_LAST) begin
                        c_nxt     = c + 5'd1;
                        state_nxt = ADDR;
                    end else if (p != P_LAST) begin
                        p_nxt     = p + PW'(1);
                        c_nxt     = '0;
`ifdef PMU_COLLECT_HEADER_EN
                        state_nxt = HDR;
`else
                        state_nxt = ADDR;
`endif
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
`ifdef PMU_COLLECT_HEADER_EN
            HDR: begin
                if (hs) begin
                    state_nxt = ADDR;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the upcoming state so they align with it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pmu_addr_o   <= '0;
            out_tvalid_o <= 1'b0;
            out_tdata_o  <= '0;
            out_tlast_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            busy_o <= (state_nxt != IDLE) && (state_nxt != DONE);
            done_o <= (state_nxt == DONE);
`ifdef PMU_COLLECT_HEADER_EN
            out_tvalid_o <= (state_nxt == OUT) || (state_nxt == HDR);
`else
            out_tvalid_o <= (state_nxt == OUT);
`endif
            if (state_nxt == ADDR) begin
                pmu_addr_o <= {NUM_PMU{c_nxt}};
            end
            if (hs) begin
                out_tlast_o <= 1'b0;
            end
            if (capture) begin
                out_tdata_o <= pmu_data_i[p];
                out_tlast_o <= (p == P_LAST) && (c == C_LAST);
            end
`ifdef PMU_COLLECT_HEADER_EN
            if ((state_nxt == HDR) && (state != HDR)) begin
                out_tdata_o <= hdr_word;
                out_tlast_o <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pmu_snapshot_collector.sv
// Directed bench for pmu_snapshot_collector: default instance plus two small
// instances exercising READ_LAT=3 and READ_LAT=0 against PMU data models.
`timescale 1ns/1ps
module tb_pmu_snapshot_collector;

    localparam int NP = 16;
    localparam int NC = 32;
    localparam int W  = 64;
    localparam int SNP = 2;
    localparam int SNC = 4;
`ifdef PMU_COLLECT_HEADER_EN
    localparam int HDR_W = 1;
`else
    localparam int HDR_W = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn;

    // Default instance signals
    logic                    start, tvalid, tready, tlast, busy, done;
    logic [NP-1:0]           idle;
    logic [NP-1:0][4:0]      addr, addr_q;
    logic [NP-1:0][W-1:0]    data;
    logic [W-1:0]            tdata;

    // READ_LAT=3 instance (a) and READ_LAT=0 instance (b)
    logic                    start_s, tvalid_a, tready_s, tlast_a, busy_a, done_a;
    logic                    tvalid_b, tlast_b, busy_b, done_b;
    logic [SNP-1:0]          idle_s;
    logic [SNP-1:0][4:0]     addr_a, a_s1, a_s2, a_s3, addr_b;
    logic [SNP-1:0][W-1:0]   data_a, data_b;
    logic [W-1:0]            tdata_a, tdata_b;

    function automatic logic [63:0] pat(input int i, input int a);
        return {16'hC0DE, 8'(i), 32'h0, 8'(a)};
    endfunction

    function automatic int exp_total(input int np_, input int nc_);
        return np_ * (nc_ + HDR_W);
    endfunction

    function automatic logic [63:0] exp_word(input int np_, input int nc_, input int k);
        int blk;
        int pi;
        int j;
        blk = nc_ + HDR_W;
        pi  = k / blk;
        j   = k % blk;
        if (HDR_W != 0 && j == 0) return {8'hA5, 8'(pi), 8'(nc_), 40'h0};
        return pat(pi, j - HDR_W);
    endfunction

    // PMU models: one-cycle registered read, three-cycle pipeline, combinational
    always @(posedge aclk) begin
        addr_q <= addr;
        a_s1   <= addr_a;
        a_s2   <= a_s1;
        a_s3   <= a_s2;
    end
    for (genvar g = 0; g < NP; g++) begin : g_main_model
        assign data[g] = pat(g, int'(addr_q[g]));
    end
    for (genvar g = 0; g < SNP; g++) begin : g_small_model
        assign data_a[g] = pat(g, int'(a_s3[g]));
        assign data_b[g] = pat(g, int'(addr_b[g]));
    end

    pmu_snapshot_collector #(.NUM_PMU(NP), .NUM_CNT(NC), .CNT_WIDTH(W), .READ_LAT(1), .SETTLE_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .start_i(start), .idle_i(idle),
        .pmu_addr_o(addr), .pmu_data_i(data),
        .out_tvalid_o(tvalid), .out_tready_i(tready), .out_tdata_o(tdata), .out_tlast_o(tlast),
        .busy_o(busy), .done_o(done));

    pmu_snapshot_collector #(.NUM_PMU(SNP), .NUM_CNT(SNC), .CNT_WIDTH(W), .READ_LAT(3), .SETTLE_CYCLES(2)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .start_i(start_s), .idle_i(idle_s),
        .pmu_addr_o(addr_a), .pmu_data_i(data_a),
        .out_tvalid_o(tvalid_a), .out_tready_i(tready_s), .out_tdata_o(tdata_a), .out_tlast_o(tlast_a),
        .busy_o(busy_a), .done_o(done_a));

    pmu_snapshot_collector #(.NUM_PMU(SNP), .NUM_CNT(SNC), .CNT_WIDTH(W), .READ_LAT(0), .SETTLE_CYCLES(2)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .start_i(start_s), .idle_i(idle_s),
        .pmu_addr_o(addr_b), .pmu_data_i(data_b),
        .out_tvalid_o(tvalid_b), .out_tready_i(tready_s), .out_tdata_o(tdata_b), .out_tlast_o(tlast_b),
        .busy_o(busy_b), .done_o(done_b));

    // Observations gathered by collect()
    logic [63:0] got_data[$];
    logic        got_last[$];
    int c_busy, c_done, c_overlap, c_stall, c_timeout;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    // Entered and left at posedge+1; leaves the bench in the first busy cycle
    task automatic pulse_start();
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    // Runs the default instance until one cycle after done, recording stream and flags
    task automatic collect(input int ready_pct, input int extra_start_at);
        logic        pv, pr, pl;
        logic [63:0] pd;
        bit          seen_done;
        int          cyc;
        got_data.delete();
        got_last.delete();
        c_busy = 0; c_done = 0; c_overlap = 0; c_stall = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        seen_done = 1'b0;
        for (cyc = 0; cyc < 10000; cyc++) begin
            tready = (int'($urandom_range(0, 99)) < ready_pct);
            start  = (cyc == extra_start_at);
            if (busy) c_busy++;
            if (done) c_done++;
            if (busy && done) c_overlap++;
            if (pv && !pr && (!tvalid || tdata !== pd || tlast !== pl)) c_stall++;
            if (tvalid && tready) begin
                got_data.push_back(tdata);
                got_last.push_back(tlast);
            end
            pv = tvalid; pr = tready; pd = tdata; pl = tlast;
            if (seen_done) break;
            if (done) seen_done = 1'b1;
            @(posedge aclk); #1;
        end
        c_timeout = seen_done ? 0 : 1;
        start  = 1'b0;
        tready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        start = 1'b0; tready = 1'b0; idle = '1;
        start_s = 1'b0; tready_s = 1'b0; idle_s = '1;
        repeat (3) @(posedge aclk);
        #1;
        n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
        n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", tlast); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (tdata !== 64'h0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
        n_checks++; if (addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_full_scan();
        int total;
        total = exp_total(NP, NC);
        idle = '1;
        pulse_start();
        collect(100, -1);
        n_checks++; if (c_timeout != 0) begin n_fail++; $display("FAIL full_timeout: got timeout expected done"); end
        n_checks++; if (got_data.size() != total) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", got_data.size(), total); end
        for (int k = 0; k < got_data.size() && k < total; k++) begin
            n_checks++;
            if (got_data[k] !== exp_word(NP, NC, k)) begin n_fail++; $display("FAIL full_word[%0d]: got %h expected %h", k, got_data[k], exp_word(NP, NC, k)); end
            n_checks++;
            if (got_last[k] !== (k == total - 1)) begin n_fail++; $display("FAIL full_last[%0d]: got %b expected %b", k, got_last[k], (k == total - 1)); end
        end
        n_checks++; if (c_done != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", c_done); end
        n_checks++; if (c_overlap != 0) begin n_fail++; $display("FAIL full_busy_done_overlap: got %0d expected 0", c_overlap); end
        n_checks++;
        if (c_busy != 8 + NP * NC * 4 + HDR_W * NP) begin
            n_fail++; $display("FAIL full_busy_cycles: got %0d expected %0d", c_busy, 8 + NP * NC * 4 + HDR_W * NP);
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_idle_settle();
        int saw_valid;
        int cnt;
        int total;
        total = exp_total(NP, NC);
        idle = '1;
        idle[5] = 1'b0;
        tready = 1'b0;
        saw_valid = 0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (i == 8)  idle[5] = 1'b1;
            if (i == 12) idle[5] = 1'b0;
            if (tvalid) saw_valid++;
            @(posedge aclk); #1;
        end
        n_checks++; if (saw_valid != 0) begin n_fail++; $display("FAIL settle_early_valid: got %0d expected 0", saw_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL settle_busy: got %b expected 1", busy); end
        idle[5] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge aclk); #1;
            cnt++;
            if (tvalid) break;
        end
        // 8 settle cycles, then ADDR + one WAIT_DATA + capture edge
        n_checks++;
        if (cnt != (HDR_W != 0 ? 8 : 11)) begin
            n_fail++; $display("FAIL settle_latency: got %0d expected %0d", cnt, (HDR_W != 0 ? 8 : 11));
        end
        collect(100, -1);
        n_checks++; if (got_data.size() != total) begin n_fail++; $display("FAIL settle_count: got %0d expected %0d", got_data.size(), total); end
        if (got_data.size() > 0) begin
            n_checks++; if (got_data[0] !== exp_word(NP, NC, 0)) begin n_fail++; $display("FAIL settle_first: got %h expected %h", got_data[0], exp_word(NP, NC, 0)); end
        end
    endtask

    task automatic test_backpressure();
        int total;
        total = exp_total(NP, NC);
        idle = '1;
        pulse_start();
        collect(30, 50);
        n_checks++; if (c_timeout != 0) begin n_fail++; $display("FAIL bp_timeout: got timeout expected done"); end
        n_checks++; if (got_data.size() != total) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_data.size(), total); end
        for (int k = 0; k < got_data.size() && k < total; k++) begin
            n_checks++;
            if (got_data[k] !== exp_word(NP, NC, k)) begin n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", k, got_data[k], exp_word(NP, NC, k)); end
            n_checks++;
            if (got_last[k] !== (k == total - 1)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b expected %b", k, got_last[k], (k == total - 1)); end
        end
        n_checks++; if (c_stall != 0) begin n_fail++; $display("FAIL bp_stall_stability: got %0d changes expected 0", c_stall); end
        n_checks++; if (c_done != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", c_done); end
    endtask

    task automatic test_reset_mid();
        int hs;
        int total;
        total = exp_total(NP, NC);
        idle = '1;
        tready = 1'b1;
        hs = 0;
        pulse_start();
        for (int cyc = 0; cyc < 3000 && hs < 100; cyc++) begin
            if (tvalid) hs++;
            @(posedge aclk); #1;
        end
        n_checks++; if (hs != 100) begin n_fail++; $display("FAIL rst_mid_progress: got %0d expected 100", hs); end
        aresetn = 1'b0;
        #1;
        n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid: got %b expected 0", tvalid); end
        n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tlast: got %b expected 0", tlast); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (tdata !== 64'h0) begin n_fail++; $display("FAIL rst_mid_tdata: got %h expected 0", tdata); end
        n_checks++; if (addr !== '0) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected 0", addr); end
        tready = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        pulse_start();
        collect(100, -1);
        n_checks++; if (got_data.size() != total) begin n_fail++; $display("FAIL rst_restart_count: got %0d expected %0d", got_data.size(), total); end
        for (int k = 0; k < got_data.size() && k < total; k++) begin
            n_checks++;
            if (got_data[k] !== exp_word(NP, NC, k)) begin n_fail++; $display("FAIL rst_restart_word[%0d]: got %h expected %h", k, got_data[k], exp_word(NP, NC, k)); end
            n_checks++;
            if (got_last[k] !== (k == total - 1)) begin n_fail++; $display("FAIL rst_restart_last[%0d]: got %b expected %b", k, got_last[k], (k == total - 1)); end
        end
    endtask

    task automatic test_read_latency();
        logic [63:0] qa[$], qb[$];
        logic        la[$], lb[$];
        int          ta[$], tb[$];
        int          total;
        total = exp_total(SNP, SNC);
        idle_s = '1;
        tready_s = 1'b1;
        start_s = 1'b1;
        @(posedge aclk); #1;
        start_s = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (tvalid_a) begin qa.push_back(tdata_a); la.push_back(tlast_a); ta.push_back(cyc); end
            if (tvalid_b) begin qb.push_back(tdata_b); lb.push_back(tlast_b); tb.push_back(cyc); end
            @(posedge aclk); #1;
        end
        tready_s = 1'b0;
        n_checks++; if (qa.size() != total) begin n_fail++; $display("FAIL lat3_count: got %0d expected %0d", qa.size(), total); end
        n_checks++; if (qb.size() != total) begin n_fail++; $display("FAIL lat0_count: got %0d expected %0d", qb.size(), total); end
        for (int k = 0; k < qa.size() && k < total; k++) begin
            n_checks++;
            if (qa[k] !== exp_word(SNP, SNC, k)) begin n_fail++; $display("FAIL lat3_word[%0d]: got %h expected %h", k, qa[k], exp_word(SNP, SNC, k)); end
            n_checks++;
            if (la[k] !== (k == total - 1)) begin n_fail++; $display("FAIL lat3_last[%0d]: got %b expected %b", k, la[k], (k == total - 1)); end
        end
        for (int k = 0; k < qb.size() && k < total; k++) begin
            n_checks++;
            if (qb[k] !== exp_word(SNP, SNC, k)) begin n_fail++; $display("FAIL lat0_word[%0d]: got %h expected %h", k, qb[k], exp_word(SNP, SNC, k)); end
            n_checks++;
            if (lb[k] !== (k == total - 1)) begin n_fail++; $display("FAIL lat0_last[%0d]: got %b expected %b", k, lb[k], (k == total - 1)); end
        end
        // Two consecutive counter words are READ_LAT+3 cycles apart with tready high
        if (ta.size() > HDR_W + 1) begin
            n_checks++;
            if (ta[HDR_W + 1] - ta[HDR_W] != 6) begin n_fail++; $display("FAIL lat3_word_period: got %0d expected 6", ta[HDR_W + 1] - ta[HDR_W]); end
        end
        if (tb.size() > HDR_W + 1) begin
            n_checks++;
            if (tb[HDR_W + 1] - tb[HDR_W] != 3) begin n_fail++; $display("FAIL lat0_word_period: got %0d expected 3", tb[HDR_W + 1] - tb[HDR_W]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_idle_settle();
        test_backpressure();
        test_reset_mid();
        test_read_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
